// File: rtl/branch_pkg.sv
// Shared types and constants for the branch control-step sequencer.
package branch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T3   = 3'd1,
    T4   = 3'd2,
    T5   = 3'd3,
    T6   = 3'd4,
    FIN  = 3'd5
  } state_t;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

  // C2 condition codes as seen by CON_FF (IR[20:19]); decoded there, not here
  localparam logic [1:0] C2_ZERO     = 2'b00;
  localparam logic [1:0] C2_NONZERO  = 2'b01;
  localparam logic [1:0] C2_POSITIVE = 2'b10;
  localparam logic [1:0] C2_NEGATIVE = 2'b11;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int C2_MSB  = 22;
  localparam int C2_LSB  = 19;
  localparam int C_MSB   = 18;
  localparam int C_LSB   = 0;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= 16'h0000;
    end else if (inc && (q != 16'hFFFF)) begin
      q <= q + 16'h0001;
    end
  end

endmodule

// File: rtl/branch_sequencer.sv
// Issues the T3..T6 register-transfer strobes of a conditional branch and
// keeps saturating executed/taken branch counts.
module branch_sequencer
  import branch_pkg::*;
#(
  parameter logic [4:0] BR_OPCODE  = BR_OPCODE_DEF,
  parameter bit         EARLY_EXIT = 1'b1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        con_out,
  output logic        gra,
  output logic        r_out,
  output logic        con_in,
  output logic        pc_out,
  output logic        y_in,
  output logic        c_out,
  output logic        alu_add,
  output logic        z_in,
  output logic        zlow_out,
  output logic        pc_in,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] branch_cnt,
  output logic [15:0] taken_cnt
);

  state_t state_q, state_d;
  logic   taken_q;
  logic   unused_ir;

  // Only the opcode matters here; the remaining fields feed the datapath and CON_FF.
  assign unused_ir = ^{ir[RA_MSB:RA_LSB], ir[C2_MSB:C2_LSB], ir[C_MSB:C_LSB]};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      taken_q <= 1'b0;
      taken   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == T4) taken_q <= con_out;
      if (state_q == FIN) taken <= taken_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    gra      = 1'b0;
    r_out    = 1'b0;
    con_in   = 1'b0;
    pc_out   = 1'b0;
    y_in     = 1'b0;
    c_out    = 1'b0;
    alu_add  = 1'b0;
    z_in     = 1'b0;
    zlow_out = 1'b0;
    busy     = (state_q != IDLE);
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (ir[OPC_MSB:OPC_LSB] == BR_OPCODE)) state_d = T3;
      end
      T3: begin
        gra     = 1'b1;
        r_out   = 1'b1;
        con_in  = 1'b1;
        state_d = T4;
      end
      T4: begin
        pc_out  = 1'b1;
        y_in    = 1'b1;
        state_d = (EARLY_EXIT && !con_out) ? FIN : T5;
      end
      T5: begin
        c_out   = 1'b1;
        alu_add = 1'b1;
        z_in    = 1'b1;
        state_d = T6;
      end
      T6: begin
        zlow_out = 1'b1;
        state_d  = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Not Moore: qualified by the decision latched in T4, drops with the async reset.
  assign pc_in = (state_q == T6) && taken_q;

  sat_counter16 u_branch_cnt (
    .clk (clk),
    .clr (clr),
    .inc (state_q == FIN),
    .q   (branch_cnt)
  );

  sat_counter16 u_taken_cnt (
    .clk (clk),
    .clr (clr),
    .inc ((state_q == FIN) && taken_q),
    .q   (taken_cnt)
  );

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench: two sequencers (early exit on / off) on shared inputs,
// table vectors, hand corner sequences, random run vs. model, counter saturation.
module tb_branch_sequencer;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        con_out = 1'b0;
  logic [31:0] ir = 32'h0;

  logic gra_a, r_out_a, con_in_a, pc_out_a, y_in_a, c_out_a, alu_add_a, z_in_a;
  logic zlow_out_a, pc_in_a, busy_a, done_a, taken_a;
  logic gra_b, r_out_b, con_in_b, pc_out_b, y_in_b, c_out_b, alu_add_b, z_in_b;
  logic zlow_out_b, pc_in_b, busy_b, done_b, taken_b;
  logic [15:0] bc_a, tc_a, bc_b, tc_b;

  logic        sat_clr = 1'b1;
  logic        sat_inc = 1'b0;
  logic [15:0] sat_q;

  always #5 clk = ~clk;

  branch_sequencer #(.BR_OPCODE(BR_OPCODE_DEF), .EARLY_EXIT(1'b1)) dut_a (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .con_out(con_out),
    .gra(gra_a), .r_out(r_out_a), .con_in(con_in_a), .pc_out(pc_out_a), .y_in(y_in_a),
    .c_out(c_out_a), .alu_add(alu_add_a), .z_in(z_in_a), .zlow_out(zlow_out_a),
    .pc_in(pc_in_a), .busy(busy_a), .done(done_a), .taken(taken_a),
    .branch_cnt(bc_a), .taken_cnt(tc_a)
  );

  branch_sequencer #(.BR_OPCODE(BR_OPCODE_DEF), .EARLY_EXIT(1'b0)) dut_b (
    .clk(clk), .clr(clr), .start(start), .ir(ir), .con_out(con_out),
    .gra(gra_b), .r_out(r_out_b), .con_in(con_in_b), .pc_out(pc_out_b), .y_in(y_in_b),
    .c_out(c_out_b), .alu_add(alu_add_b), .z_in(z_in_b), .zlow_out(zlow_out_b),
    .pc_in(pc_in_b), .busy(busy_b), .done(done_b), .taken(taken_b),
    .branch_cnt(bc_b), .taken_cnt(tc_b)
  );

  sat_counter16 u_sat (.clk(clk), .clr(sat_clr), .inc(sat_inc), .q(sat_q));

  // bit order: gra r_out con_in pc_out y_in c_out alu_add z_in zlow_out pc_in busy done taken
  logic [12:0] obs_a, obs_b;
  assign obs_a = {gra_a, r_out_a, con_in_a, pc_out_a, y_in_a, c_out_a, alu_add_a, z_in_a,
                  zlow_out_a, pc_in_a, busy_a, done_a, taken_a};
  assign obs_b = {gra_b, r_out_b, con_in_b, pc_out_b, y_in_b, c_out_b, alu_add_b, z_in_b,
                  zlow_out_b, pc_in_b, busy_b, done_b, taken_b};

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op);
    return {op, 4'd3, 2'b00, C2_NONZERO, 19'd16};
  endfunction

  // ---------------- table-driven branch vectors ----------------
  typedef struct {
    logic [4:0] op;
    logic       con;
    int         lat_a;   // done latency, early exit on (0 = never)
    int         lat_b;   // done latency, early exit off
    logic       tk;
    logic       c_seen_a;
  } vec_t;

  int exp_bc_a, exp_tc_a, exp_bc_b, exp_tc_b;

  task automatic run_vec(input vec_t v, input string tag);
    int   la, lb, nda, ndb, nbusy;
    logic pa, pb, ca;
    la = 0; lb = 0; nda = 0; ndb = 0; nbusy = 0; pa = 0; pb = 0; ca = 0;
    @(negedge clk);
    ir = mk_ir(v.op); con_out = v.con; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (v.op == BR_OPCODE_DEF) chk({tag, "_t3_strobes"}, {29'd0, gra_a, r_out_a, con_in_a}, 32'd7);
    for (int c = 1; c <= 8; c++) begin
      if (done_a) begin nda++; if (la == 0) la = c; end
      if (done_b) begin ndb++; if (lb == 0) lb = c; end
      pa |= pc_in_a; pb |= pc_in_b; ca |= c_out_a | z_in_a;
      if (busy_a) nbusy++;
      @(negedge clk);
    end
    chk({tag, "_lat_a"}, la, v.lat_a);
    chk({tag, "_lat_b"}, lb, v.lat_b);
    chk({tag, "_ndone_a"}, nda, (v.lat_a != 0) ? 1 : 0);
    chk({tag, "_ndone_b"}, ndb, (v.lat_b != 0) ? 1 : 0);
    chk({tag, "_busy_cycles_a"}, nbusy, v.lat_a);
    chk({tag, "_pc_in_a"}, pa, v.tk);
    chk({tag, "_pc_in_b"}, pb, v.tk);
    chk({tag, "_c_z_seen_a"}, ca, v.c_seen_a);
    if (v.lat_a != 0) begin
      exp_bc_a++; exp_bc_b++;
      if (v.tk) begin exp_tc_a++; exp_tc_b++; end
      chk({tag, "_taken_a"}, taken_a, v.tk);
      chk({tag, "_taken_b"}, taken_b, v.tk);
    end
    chk({tag, "_bc_a"}, bc_a, exp_bc_a);
    chk({tag, "_tc_a"}, tc_a, exp_tc_a);
    chk({tag, "_bc_b"}, bc_b, exp_bc_b);
    chk({tag, "_tc_b"}, tc_b, exp_tc_b);
  endtask

  // Abort with clr, mid-cycle, at the given step (3 = T5, 4 = T6) of a taken branch.
  task automatic abort_at(input int step, input string tag);
    @(negedge clk);
    ir = mk_ir(BR_OPCODE_DEF); con_out = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (step - 1) @(negedge clk);
    if (step == 4) chk({tag, "_pc_in_before"}, pc_in_a, 1'b1);
    #2 clr = 1'b1;
    #1;
    chk({tag, "_obs_a"}, obs_a, 13'd0);
    chk({tag, "_obs_b"}, obs_b, 13'd0);
    chk({tag, "_cnts"}, {bc_a, tc_a}, 32'd0);
    exp_bc_a = 0; exp_tc_a = 0; exp_bc_b = 0; exp_tc_b = 0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  // ---------------- reference model for random run ----------------
  // Each sequencer is tracked as "cycles into the current branch" plus the
  // branch length chosen once the condition is known.
  int   m_step[2], m_len[2], m_bc[2], m_tc[2];
  bit   m_tkp[2], m_tkd[2];
  bit   m_ee[2] = '{1'b1, 1'b0};

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_step[i] = 0; m_len[i] = 5; m_bc[i] = 0; m_tc[i] = 0; m_tkp[i] = 0; m_tkd[i] = 0;
    end
  endtask

  function automatic logic [12:0] model_obs(input int i);
    logic [12:0] v;
    v = '0;
    if (m_step[i] == 1) v[12:10] = 3'b111;
    else if (m_step[i] == 2) v[9:8] = 2'b11;
    else if (m_step[i] >= 3) begin
      if (m_step[i] == m_len[i]) v[1] = 1'b1;
      else if (m_step[i] == 3) v[7:5] = 3'b111;
      else begin v[4] = 1'b1; v[3] = m_tkp[i]; end
    end
    v[2] = (m_step[i] != 0);
    v[0] = m_tkd[i];
    return v;
  endfunction

  task automatic model_clock();
    for (int i = 0; i < 2; i++) begin
      if (m_step[i] == 0) begin
        if (start && (ir[31:27] == BR_OPCODE_DEF)) m_step[i] = 1;
      end else if (m_step[i] == 2) begin
        m_tkp[i] = con_out;
        m_len[i] = (m_ee[i] && !con_out) ? 3 : 5;
        m_step[i] = 3;
      end else if (m_step[i] == m_len[i]) begin
        m_step[i] = 0;
        m_tkd[i] = m_tkp[i];
        if (m_bc[i] < 65535) m_bc[i]++;
        if (m_tkp[i] && m_tc[i] < 65535) m_tc[i]++;
      end else begin
        m_step[i]++;
      end
    end
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{BR_OPCODE_DEF, 1'b1, 5, 5, 1'b1, 1'b1};
    vecs[1] = '{BR_OPCODE_DEF, 1'b0, 3, 5, 1'b0, 1'b0};
    vecs[2] = '{5'b00011,      1'b1, 0, 0, 1'b0, 1'b0};
    vecs[3] = '{BR_OPCODE_DEF, 1'b1, 5, 5, 1'b1, 1'b1};
    vecs[4] = '{5'b10011,      1'b0, 0, 0, 1'b0, 1'b0};
    exp_bc_a = 0; exp_tc_a = 0; exp_bc_b = 0; exp_tc_b = 0;

    // reset held two cycles
    repeat (2) @(negedge clk);
    clr = 1'b0;
    sat_clr = 1'b0;
    @(negedge clk);
    chk("reset_obs_a", obs_a, 13'd0);
    chk("reset_obs_b", obs_b, 13'd0);
    chk("reset_cnt_a", {bc_a, tc_a}, 32'd0);
    chk("reset_cnt_b", {bc_b, tc_b}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // start re-asserted during T4 is ignored: one done, five busy cycles
    begin
      int nda, ndb, nba, nbb;
      nda = 0; ndb = 0; nba = 0; nbb = 0;
      @(negedge clk);
      ir = mk_ir(BR_OPCODE_DEF); con_out = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c <= 10; c++) begin
        start = (c == 2);
        nda += done_a; ndb += done_b; nba += busy_a; nbb += busy_b;
        @(negedge clk);
      end
      start = 1'b0;
      chk("busy_start_ndone_a", nda, 1);
      chk("busy_start_ndone_b", ndb, 1);
      chk("busy_start_busy_a", nba, 5);
      chk("busy_start_busy_b", nbb, 5);
      exp_bc_a++; exp_tc_a++; exp_bc_b++; exp_tc_b++;
      chk("busy_start_bc_a", bc_a, exp_bc_a);
    end

    abort_at(3, "abort_t5");
    run_vec(vecs[0], "after_abort_t5");
    abort_at(4, "abort_t6");
    run_vec(vecs[1], "after_abort_t6");

    // random run against the model
    @(negedge clk);
    clr = 1'b1;
    #1 clr = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      chk("rand_obs_a", obs_a, model_obs(0));
      chk("rand_obs_b", obs_b, model_obs(1));
      chk("rand_cnt_a", {bc_a, tc_a}, {m_bc[0][15:0], m_tc[0][15:0]});
      chk("rand_cnt_b", {bc_b, tc_b}, {m_bc[1][15:0], m_tc[1][15:0]});
      start   = ($urandom_range(0, 3) != 0);
      ir      = $urandom;
      if ($urandom_range(0, 2) != 0) ir[31:27] = BR_OPCODE_DEF;
      con_out = $urandom_range(0, 1);
      model_clock();
    end
    start = 1'b0;

    // counter saturation at all-ones
    @(negedge clk);
    sat_inc = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    chk("sat_fffe", sat_q, 16'hFFFE);
    @(negedge clk);
    chk("sat_ffff", sat_q, 16'hFFFF);
    repeat (3) @(negedge clk);
    chk("sat_hold", sat_q, 16'hFFFF);
    sat_inc = 1'b0;
    sat_clr = 1'b1;
    #1;
    chk("sat_clr", sat_q, 16'h0000);
    sat_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-step sequencer for conditional branch instructions, on the control-unit side of the condition flip-flop (CON_FF). After fetch and decode, it issues the T3–T6 register-transfer strobes for a branch: latch the condition in CON_FF, form PC + C in the ALU, and load PC only when CON_FF reports the condition true. It also keeps saturating counts of executed and taken branches for performance debug.

## Interface
- BR_OPCODE, 5'b10010: IR[31:27] value identifying a branch.
- EARLY_EXIT, 1: 1 = a not-taken branch finishes after T4; 0 = every branch runs T3–T6.
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  IR holds a freshly decoded instruction; sampled only in IDLE.
- ir  in  32  instruction register: opcode IR[31:27], Ra IR[26:23], C2 IR[22:19] (CON_FF uses IR[20:19]), C IR[18:0].
- con_out  in  1  CON_FF output.
- gra, r_out, con_in  out  1 each  T3 strobes: select Ra, drive Ra onto the bus, latch CON_FF.
- pc_out, y_in  out  1 each  T4 strobes.
- c_out, alu_add, z_in  out  1 each  T5 strobes: sign-extended C onto the bus, ALU add, load Z.
- zlow_out, pc_in  out  1 each  T6 strobes; pc_in is qualified by the taken decision.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- taken  out  1  taken decision of the last completed branch.
- branch_cnt  out  16  branches completed, saturating.
- taken_cnt  out  16  branches taken, saturating.

## Operation
- States: IDLE, T3, T4, T5, T6, FIN. Outputs are Moore-decoded from the state, except pc_in.
- IDLE: all strobes are 0.
  - start=1 and ir[31:27]==BR_OPCODE → T3.
  - start=1 with any other opcode: ignored; stay in IDLE; no done.
- T3: gra=r_out=con_in=1 → T4.
- T4: pc_out=y_in=1. taken_q <= con_out. con_out is valid because CON_FF latched on the T3→T4 edge.
  - EARLY_EXIT=1 and con_out=0 → FIN.
  - Otherwise → T5.
- T5: c_out=alu_add=z_in=1 → T6.
- T6: zlow_out=1; pc_in=taken_q → FIN.
- FIN: done=1; taken <= taken_q; branch_cnt += 1; taken_cnt += taken_q → IDLE.
- Counters saturate at 16'hFFFF and never wrap.
- The sequencer never decodes the condition itself; con_out is the only source of the taken decision.
- start while busy=1 is ignored and has no effect on the branch in progress.

## Timing
- Reset (clr=1, async): state=IDLE; every strobe, busy, done, taken and taken_q = 0; both counters = 0.
  - clr mid-branch aborts immediately: pc_in drops in the same cycle and nothing increments.
  - Exit on the first rising clk edge after clr falls.
- Latency from the edge that samples start to the done pulse:
  - Full path: 5 cycles (T3, T4, T5, T6, FIN).
  - Early exit: 3 cycles (T3, T4, FIN).
- Back-to-back: the earliest next start is sampled in the IDLE cycle after FIN. Throughput is 1 branch per 6 cycles (full) or 4 cycles (early exit).
- Each strobe is high for exactly one cycle per branch. No two step groups overlap.
- taken changes only on the FIN edge and holds its value until the next FIN or clr.

## Structure
- Shared package branch_pkg:
  - state enum (IDLE, T3, T4, T5, T6, FIN);
  - BR_OPCODE default;
  - C2 condition codes (00 zero, 01 nonzero, 10 positive, 11 negative);
  - IR field position constants.
- Sub-module sat_counter16 (inc, clr, q), instantiated twice for branch_cnt and taken_cnt.
- FSM and output decode live in branch_sequencer itself.

## Test plan
- Reset: hold clr=1 for 2 cycles, release → all outputs 0, state IDLE; start=1 in the next cycle → gra/r_out/con_in high exactly 1 cycle later.
- Taken, full path: ir=32'h91880010 (opcode 10010, Ra=3, C2=0001 brnz, C=16), con_out=1 → strobe groups T3..T6 in order; pc_in=1 in T6; done 5 cycles after start; taken=1; branch_cnt=1, taken_cnt=1.
- Not taken, EARLY_EXIT=1, same ir, con_out=0 → no c_out/z_in/pc_in ever; done 3 cycles after start; taken=0; branch_cnt=1, taken_cnt=0. With EARLY_EXIT=0 → T5/T6 still run, pc_in stays 0, done at 5 cycles.
- Non-branch and busy starts: start with ir[31:27]=5'b00011 → no strobes, busy stays 0. start re-asserted during T4 of a branch → ignored; exactly one done.
- Abort: assert clr during T5 → all strobes 0 in the same cycle without a clk edge; counters 0; next branch runs normally.
- Saturation: force 65 536 taken branches → branch_cnt=taken_cnt=16'hFFFF and they stay there after one more branch.
